// File: rtl/dbus_sram_responder.sv
// rtl/dbus_sram_responder.sv - data-bus responder modelling a latency-configurable 64-bit data SRAM

typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
} dbus_req_t;

typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
} dbus_resp_t;

module dbus_sram_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  dbus_req_t   dreq,
    output dbus_resp_t  dresp,
    output logic        busy,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
);
    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, next_state;

    logic [3:0]    lat_cnt;
    logic [AW-1:0] lat_idx;
    logic [7:0]    lat_strobe;
    logic [63:0]   lat_data;
    logic [63:0]   resp_data;
    logic [63:0]   mem [DEPTH];

    // Byte offset and bits above the array size are dropped, so addresses alias.
    logic [AW-1:0] req_idx;
    logic [AW-1:0] rd_idx;
    logic          unused_req;
    assign req_idx    = dreq.addr[3 +: AW];
    assign unused_req = ^{dreq.addr[63:3+AW], dreq.addr[2:0], dreq.size};

    // With LATENCY==1 the array is read on the accepting edge, before the index is latched.
    assign rd_idx = (state == IDLE) ? req_idx : lat_idx;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next state: accept, count down latency (abort on dropped valid), respond once.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (dreq.valid) next_state = (LATENCY == 1) ? RESP : WAIT;
            WAIT: begin
                if (!dreq.valid)          next_state = IDLE;
                else if (lat_cnt <= 4'd1) next_state = RESP;
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Response handshake is a one-cycle pulse in RESP; data holds between responses.
    always_comb begin
        dresp         = '0;
        dresp.addr_ok = (state == RESP);
        dresp.data_ok = (state == RESP);
        dresp.data    = resp_data;
    end

    // Request latch, latency counter, pre-write readout, byte-strobed commit and counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_cnt    <= '0;
            lat_idx    <= '0;
            lat_strobe <= '0;
            lat_data   <= '0;
            resp_data  <= '0;
            busy       <= 1'b0;
            rd_count   <= '0;
            wr_count   <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            busy <= (next_state != IDLE);
            case (state)
                IDLE: begin
                    lat_cnt <= LAT_LOAD;
                    if (dreq.valid) begin
                        lat_idx    <= req_idx;
                        lat_strobe <= dreq.strobe;
                        lat_data   <= dreq.data;
                    end
                end
                WAIT: lat_cnt <= lat_cnt - 4'd1;
                RESP: begin
                    for (int b = 0; b < 8; b++) begin
                        if (lat_strobe[b]) mem[lat_idx][8*b +: 8] <= lat_data[8*b +: 8];
                    end
                    if (lat_strobe == 8'h00) rd_count <= rd_count + 32'd1;
                    else                     wr_count <= wr_count + 32'd1;
                end
                default: ;
            endcase
            if (next_state == RESP && state != RESP) resp_data <= mem[rd_idx];
        end
    end
endmodule

// File: tb/tb_dbus_sram_responder.sv
// tb/tb_dbus_sram_responder.sv - self-checking bench for dbus_sram_responder
module tb_dbus_sram_responder;
    logic        clk = 1'b0;
    logic        reset;
    dbus_req_t   req  [3];
    dbus_resp_t  resp [3];
    logic        busy [3];
    logic [31:0] rdc  [3];
    logic [31:0] wrc  [3];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dbus_sram_responder #(.DEPTH(64), .LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset), .dreq(req[0]), .dresp(resp[0]),
        .busy(busy[0]), .rd_count(rdc[0]), .wr_count(wrc[0]));
    dbus_sram_responder #(.DEPTH(64), .LATENCY(4)) u_l4 (
        .clk(clk), .reset(reset), .dreq(req[1]), .dresp(resp[1]),
        .busy(busy[1]), .rd_count(rdc[1]), .wr_count(wrc[1]));
    dbus_sram_responder #(.DEPTH(64), .LATENCY(3)) u_l3 (
        .clk(clk), .reset(reset), .dreq(req[2]), .dresp(resp[2]),
        .busy(busy[2]), .rd_count(rdc[2]), .wr_count(wrc[2]));

    typedef struct {
        int          k;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [63:0] exp_data;
        int          exp_lat;
        logic [31:0] exp_rd;
        logic [31:0] exp_wr;
    } vec_t;

    logic [63:0] mdl [2][64];
    int          mrd [2];
    int          mwr [2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input int k, input logic v, input logic [63:0] a,
                         input logic [7:0] s, input logic [63:0] d);
        dbus_req_t r;
        r.valid  = v;
        r.addr   = a;
        r.size   = 3'd3;
        r.strobe = s;
        r.data   = d;
        req[k]   = r;
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the IDLE cycle after RESP.
    task automatic txn(input int k, input logic [63:0] a, input logic [7:0] s,
                       input logic [63:0] d, output logic [63:0] rdata, output int lat);
        drive(k, 1'b1, a, s, d);
        lat   = -1;
        rdata = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (resp[k].data_ok) begin
                lat   = c;
                rdata = resp[k].data;
                break;
            end
            drive(k, 1'b1, {$urandom, $urandom}, 8'($urandom), {$urandom, $urandom});
        end
        drive(k, 1'b0, '0, '0, '0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        tbl [9];
        logic [63:0] rd;
        int          lat;
        logic        seen;

        tbl[0] = '{0, 64'h10,  8'hFF, 64'h1122334455667788, 64'h0,                 1, 0, 1};
        tbl[1] = '{0, 64'h10,  8'h00, 64'h0,                64'h1122334455667788,  1, 1, 1};
        tbl[2] = '{0, 64'h10,  8'hFF, 64'hFFFFFFFFFFFFFFFF, 64'h1122334455667788,  1, 1, 2};
        tbl[3] = '{0, 64'h14,  8'hF0, 64'h0000000012345678, 64'hFFFFFFFFFFFFFFFF,  1, 1, 3};
        tbl[4] = '{0, 64'h10,  8'h00, 64'h0,                64'h00000000FFFFFFFF,  1, 2, 3};
        tbl[5] = '{0, 64'h200, 8'hFF, 64'h5A,               64'h0,                 1, 2, 4};
        tbl[6] = '{0, 64'h0,   8'h00, 64'h0,                64'h5A,                1, 3, 4};
        tbl[7] = '{0, 64'h208, 8'h00, 64'h0,                64'h0,                 1, 4, 4};
        tbl[8] = '{1, 64'h0,   8'h00, 64'h0,                64'h0,                 4, 1, 0};

        for (int k = 0; k < 3; k++) drive(k, 1'b0, '0, '0, '0);
        reset = 1'b1;
        #2;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_resp%0d", k), {62'(0), resp[k].addr_ok, resp[k].data_ok}, 64'h0);
            chk($sformatf("reset_data%0d", k), resp[k].data, 64'h0);
            chk($sformatf("reset_busy%0d", k), 64'(busy[k]), 64'h0);
            chk($sformatf("reset_cnt%0d", k), {rdc[k], wrc[k]}, 64'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Directed vectors
        for (int i = 0; i < 9; i++) begin
            txn(tbl[i].k, tbl[i].addr, tbl[i].strobe, tbl[i].data, rd, lat);
            chk($sformatf("vec%0d_data", i), rd, tbl[i].exp_data);
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(tbl[i].exp_lat));
            chk($sformatf("vec%0d_rd", i), 64'(rdc[tbl[i].k]), 64'(tbl[i].exp_rd));
            chk($sformatf("vec%0d_wr", i), 64'(wrc[tbl[i].k]), 64'(tbl[i].exp_wr));
        end

        // LATENCY=4: busy profile and single-cycle data_ok pulse
        drive(1, 1'b1, 64'h0, 8'h00, 64'h0);
        chk("lat4_busy_c0", 64'(busy[1]), 64'h0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk($sformatf("lat4_busy_c%0d", c), 64'(busy[1]), 64'h1);
            chk($sformatf("lat4_dok_c%0d", c), 64'(resp[1].data_ok), 64'(c == 4));
        end
        drive(1, 1'b0, '0, '0, '0);
        @(negedge clk);
        chk("lat4_dok_c5", 64'(resp[1].data_ok), 64'h0);
        chk("lat4_busy_c5", 64'(busy[1]), 64'h0);

        // LATENCY=3 abort
        drive(2, 1'b1, 64'h8, 8'hFF, 64'hAA);
        @(negedge clk);
        chk("abort_busy_c1", 64'(busy[2]), 64'h1);
        drive(2, 1'b0, '0, '0, '0);
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            seen |= resp[2].data_ok;
        end
        chk("abort_no_dok", 64'(seen), 64'h0);
        chk("abort_idle", 64'(busy[2]), 64'h0);
        chk("abort_wr", 64'(wrc[2]), 64'h0);
        txn(2, 64'h8, 8'h00, 64'h0, rd, lat);
        chk("abort_word1", rd, 64'h0);
        chk("abort_lat", 64'(lat), 64'd3);
        chk("abort_rd", 64'(rdc[2]), 64'd1);

        // Async reset mid-WAIT
        drive(1, 1'b1, 64'h18, 8'hFF, 64'hDEADBEEFCAFEF00D);
        @(negedge clk);
        @(negedge clk);
        chk("rstw_busy_pre", 64'(busy[1]), 64'h1);
        #2 reset = 1'b1;
        #1;
        chk("rstw_busy", 64'(busy[1]), 64'h0);
        chk("rstw_dok", 64'(resp[1].data_ok), 64'h0);
        chk("rstw_cnt1", {rdc[1], wrc[1]}, 64'h0);
        chk("rstw_cnt0", {rdc[0], wrc[0]}, 64'h0);
        drive(1, 1'b0, '0, '0, '0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        txn(1, 64'h18, 8'h00, 64'h0, rd, lat);
        chk("rstw_word3", rd, 64'h0);
        chk("rstw_lat", 64'(lat), 64'd4);
        txn(0, 64'h10, 8'h00, 64'h0, rd, lat);
        chk("rstw_clear", rd, 64'h0);

        // Async reset mid-RESP
        drive(0, 1'b1, 64'h20, 8'hFF, 64'h77);
        @(negedge clk);
        chk("rstr_dok_pre", 64'(resp[0].data_ok), 64'h1);
        #1 reset = 1'b1;
        #1;
        chk("rstr_dok", 64'(resp[0].data_ok), 64'h0);
        drive(0, 1'b0, '0, '0, '0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        txn(0, 64'h20, 8'h00, 64'h0, rd, lat);
        chk("rstr_word4", rd, 64'h0);
        chk("rstr_cnt", {rdc[0], wrc[0]}, {32'd1, 32'd0});

        // Randomized traffic against the reference model
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            mrd[k] = 0;
            mwr[k] = 0;
            for (int w = 0; w < 64; w++) mdl[k][w] = '0;
        end
        for (int i = 0; i < 120; i++) begin
            int          k;
            int          w;
            logic [63:0] a;
            logic [7:0]  s;
            logic [63:0] d;
            logic [63:0] exp;
            k = i % 2;
            a = {$urandom, $urandom};
            a = (a & ~64'h1F8) | (64'($urandom_range(0, 7)) << 3);
            s = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
            d = {$urandom, $urandom};
            w = int'((a / 8) % 64);
            exp = mdl[k][w];
            txn(k, a, s, d, rd, lat);
            if (s == 8'h00) mrd[k]++;
            else begin
                mwr[k]++;
                for (int b = 0; b < 8; b++)
                    if (s[b]) mdl[k][w][8*b +: 8] = d[8*b +: 8];
            end
            chk($sformatf("rnd%0d_data", i), rd, exp);
            chk($sformatf("rnd%0d_lat", i), 64'(lat), (k == 0) ? 64'd1 : 64'd4);
            chk($sformatf("rnd%0d_cnt", i), {rdc[k], wrc[k]}, {32'(mrd[k]), 32'(mwr[k])});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
